// File: rtl/mult_fsm_ctrl.sv
// Control FSM for the 5x5 shift-add multiplier: conditions START, sequences
// LOAD/RUN/DONE, and guards against a B register that never reaches zero.
module mult_fsm_ctrl #(
  parameter logic [1:0]  SEL_HOLD = 2'b00,
  parameter logic [1:0]  SEL_SHL  = 2'b01,
  parameter logic [1:0]  SEL_SHR  = 2'b10,
  parameter logic [1:0]  SEL_LOAD = 2'b11,
  parameter int unsigned ITER_MAX = 5
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       START,
  input  logic       EQ,
  output logic [1:0] SEL_A,
  output logic [1:0] SEL_B,
  output logic       LD,
  output logic       ACC_CLR,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  localparam int unsigned CNT_W = $clog2(ITER_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           state, state_next;
  logic             s1, s2, s3;
  logic             start_pulse;
  logic [CNT_W-1:0] iter_cnt, iter_cnt_next;
  logic             err_next;
  logic             at_max;

  // s1 is the metastability catcher; edge detection uses only s2/s3.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= START;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign start_pulse = s2 & ~s3;
  assign at_max      = (iter_cnt == CNT_W'(ITER_MAX));

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state    <= ST_IDLE;
      iter_cnt <= '0;
      ERR      <= 1'b0;
    end else begin
      state    <= state_next;
      iter_cnt <= iter_cnt_next;
      ERR      <= err_next;
    end
  end

  always_comb begin
    state_next    = state;
    iter_cnt_next = iter_cnt;
    err_next      = ERR;
    SEL_A         = SEL_HOLD;
    SEL_B         = SEL_HOLD;
    LD            = 1'b0;
    ACC_CLR       = 1'b0;
    BUSY          = 1'b0;
    DONE          = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_pulse) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        SEL_A         = SEL_LOAD;
        SEL_B         = SEL_LOAD;
        ACC_CLR       = 1'b1;
        BUSY          = 1'b1;
        iter_cnt_next = '0;
        err_next      = 1'b0;
        state_next    = ST_RUN;
      end
      ST_RUN: begin
        BUSY = 1'b1;
        if (EQ) begin
          state_next = ST_DONE;
        end else if (at_max) begin
          err_next   = 1'b1;
          state_next = ST_DONE;
        end else begin
          // Accumulate and shift share this edge; the counter only advances
          // below ITER_MAX, so it saturates instead of wrapping.
          LD            = 1'b1;
          SEL_A         = SEL_SHL;
          SEL_B         = SEL_SHR;
          iter_cnt_next = iter_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        DONE = 1'b1;
        if (start_pulse) state_next = ST_LOAD;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_fsm_ctrl.sv
// Closed-loop bench: a behavioural 5x5 datapath plant drives EQ, and a
// scoreboard checks each multiply against plain-arithmetic expectations.
module tb_mult_fsm_ctrl;

  logic       CLK = 1'b0;
  logic       CLR_N = 1'b0;
  logic       START = 1'b0;
  logic       EQ;
  logic [1:0] SEL_A, SEL_B;
  logic       LD, ACC_CLR, BUSY, DONE, ERR;

  mult_fsm_ctrl #(.ITER_MAX(5)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .START(START), .EQ(EQ),
    .SEL_A(SEL_A), .SEL_B(SEL_B), .LD(LD), .ACC_CLR(ACC_CLR),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial forever #5 CLK = ~CLK;

  // Datapath plant
  logic [4:0] a_in = '0, b_in = '0;
  logic [9:0] a_reg = '0;
  logic [4:0] b_reg = '0;
  logic [9:0] sum = '0;
  logic       force_eq0 = 1'b0;

  assign EQ = force_eq0 ? 1'b0 : (b_reg == 5'd0);

  always @(posedge CLK) begin
    case (SEL_A)
      2'b11:   a_reg <= {5'd0, a_in};
      2'b01:   a_reg <= a_reg << 1;
      2'b10:   a_reg <= a_reg >> 1;
      default: a_reg <= a_reg;
    endcase
    case (SEL_B)
      2'b11:   b_reg <= b_in;
      2'b01:   b_reg <= b_reg << 1;
      2'b10:   b_reg <= b_reg >> 1;
      default: b_reg <= b_reg;
    endcase
    if (ACC_CLR)             sum <= '0;
    else if (LD && b_reg[0]) sum <= sum + a_reg;
  end

  typedef struct {
    int prod;
    int ld;
    int busy;
    int err;
    bit chk_sum;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int bit_len(input int v);
    int n = 0;
    while (v > 0) begin
      n++;
      v = v / 2;
    end
    return n;
  endfunction

  // Monitor
  int   ld_cnt = 0, busy_cnt = 0, prev_err = 0;
  bit   active = 0, err_chk = 0, done_d = 0;
  exp_t got;

  always @(negedge CLK) begin
    if (!CLR_N) begin
      active = 0; err_chk = 0; done_d = 0; ld_cnt = 0; busy_cnt = 0; prev_err = 0;
    end else begin
      if (ACC_CLR) begin
        chk("load_sel_a", SEL_A, 3);
        chk("load_sel_b", SEL_B, 3);
        chk("load_ld", LD, 0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_op: got LOAD expected no operation (t=%0t)", $time);
        end else begin
          active = 1; ld_cnt = 0; busy_cnt = 0;
          chk("err_through_load", ERR, prev_err);
          err_chk = 1;
        end
      end else if (err_chk) begin
        chk("err_clear_on_run", ERR, 0);
        err_chk = 0;
      end
      if (BUSY) busy_cnt++;
      if (LD) begin
        ld_cnt++;
        chk("run_sel_a", SEL_A, 1);
        chk("run_sel_b", SEL_B, 2);
        chk("run_busy", BUSY, 1);
      end
      if (DONE && !done_d) begin
        chk("done_busy", BUSY, 0);
        chk("done_sel", {SEL_A, SEL_B}, 0);
        if (!active || exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got DONE expected none (t=%0t)", $time);
        end else begin
          got = exp_q.pop_front();
          chk("ld_pulses", ld_cnt, got.ld);
          chk("busy_cycles", busy_cnt, got.busy);
          chk("err_flag", ERR, got.err);
          if (got.chk_sum) chk("product", sum, got.prod);
          prev_err = ERR;
          active = 0;
        end
      end
      done_d = DONE;
    end
  end

  task automatic wait_done(input int lim);
    int n = 0;
    while (!DONE && n < lim) begin
      @(negedge CLK);
      n++;
    end
    if (!DONE) begin
      checks++; errors++;
      $display("FAIL done_timeout: got DONE=0 expected DONE=1 within %0d cycles", lim);
    end
  endtask

  task automatic push_exp(input logic [4:0] a, input logic [4:0] b, input bit fault);
    exp_t e;
    e.prod    = int'(a) * int'(b);
    e.ld      = fault ? 5 : bit_len(int'(b));
    e.busy    = e.ld + 2;
    e.err     = fault ? 1 : 0;
    e.chk_sum = !fault;
    exp_q.push_back(e);
  endtask

  // START rise lands at a negedge; LOAD is expected after the third rising edge.
  task automatic start_and_check(input int hold);
    START = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(negedge CLK);
      if (i <= 3) chk("start_latency", ACC_CLR, (i == 3) ? 1 : 0);
    end
    START = 1'b0;
  endtask

  task automatic run_op(input logic [4:0] a, input logic [4:0] b, input int hold, input bit fault);
    a_in = a; b_in = b; force_eq0 = fault;
    push_exp(a, b, fault);
    @(negedge CLK);
    start_and_check(hold);
    wait_done(40);
    force_eq0 = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "watchdog");
  end

  logic [4:0] ra, rb;
  int         n;

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_sel", {SEL_A, SEL_B}, 0);
    chk("reset_flags", {LD, ACC_CLR, BUSY, DONE, ERR}, 0);
    CLR_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("idle_flags", {LD, ACC_CLR, BUSY, DONE, ERR}, 0);

    run_op(5'd7, 5'd5, 3, 1'b0);
    run_op(5'd31, 5'd31, 3, 1'b0);
    run_op(5'd22, 5'd0, 3, 1'b0);
    run_op(5'd9, 5'd13, 20, 1'b0);
    repeat (10) @(negedge CLK);

    // Fault guard, then the following operation clears ERR on RUN entry
    run_op(5'd3, 5'd6, 3, 1'b1);
    run_op(5'd4, 5'd3, 3, 1'b0);

    // Second START rise while in RUN must be ignored
    a_in = 5'd11; b_in = 5'd31;
    push_exp(5'd11, 5'd31, 1'b0);
    @(negedge CLK);
    start_and_check(3);
    @(negedge CLK);
    @(negedge CLK);
    START = 1'b1;
    repeat (2) @(negedge CLK);
    START = 1'b0;
    wait_done(40);
    repeat (12) @(negedge CLK);

    for (int i = 0; i < 16; i++) begin
      ra = 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      run_op(ra, rb, int'($urandom_range(3, 6)), 1'b0);
    end

    // Async reset mid-RUN, between clock edges
    a_in = 5'd19; b_in = 5'd30;
    push_exp(5'd19, 5'd30, 1'b0);
    @(negedge CLK);
    start_and_check(3);
    n = 0;
    while (!LD && n < 10) begin
      @(negedge CLK);
      n++;
    end
    chk("in_run_before_reset", LD, 1);
    #2 CLR_N = 1'b0;
    #1;
    chk("async_ld", LD, 0);
    chk("async_busy", BUSY, 0);
    chk("async_sel", {SEL_A, SEL_B}, 0);
    chk("async_acc_clr", ACC_CLR, 0);
    void'(exp_q.pop_front());
    repeat (2) @(negedge CLK);
    CLR_N = 1'b1;
    repeat (10) @(negedge CLK);
    chk("post_reset_idle", {BUSY, DONE, ERR}, 0);
    run_op(5'd17, 5'd23, 3, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_fsm_ctrl.md
Name: mult_fsm_ctrl

Overview:
- Controller for the 5x5 shift-add multiplier datapath. Drives the datapath's A/B shift-register selects, accumulator load and accumulator clear, and consumes its B==0 compare flag (EQ).
- Sits directly upstream of the datapath. Takes a raw START button and reports BUSY/DONE/ERR to the top level.
- Moore state machine, except LD and the shift selects in RUN, which are qualified by EQ.

Parameters:
- SEL_HOLD, 2'b00, universal shift-register select code: hold.
- SEL_SHL, 2'b01, select code: shift left, 0 shifted in.
- SEL_SHR, 2'b10, select code: shift right, 0 shifted in.
- SEL_LOAD, 2'b11, select code: parallel load.
- ITER_MAX, 5, maximum accumulate cycles (B operand width); must be at least 1.

Ports:
- CLK, in, 1, system clock; all state updates on the rising edge.
- CLR_N, in, 1, asynchronous active-low reset.
- START, in, 1, raw asynchronous start request (button).
- EQ, in, 1, datapath flag: B register == 0.
- SEL_A, out, 2, select for the A (multiplicand) shift register.
- SEL_B, out, 2, select for the B (multiplier) shift register.
- LD, out, 1, accumulator load enable.
- ACC_CLR, out, 1, accumulator clear; one cycle wide.
- BUSY, out, 1, high in LOAD and RUN.
- DONE, out, 1, high in DONE; product valid on the datapath SUM.
- ERR, out, 1, sticky iteration-overflow flag.

Behaviour:
- Reset (CLR_N=0, takes effect immediately, no clock needed):
  - state=IDLE, synchronizer flops=0, iteration counter=0, ERR=0.
  - Outputs: SEL_A=SEL_B=SEL_HOLD, LD=0, ACC_CLR=0, BUSY=0, DONE=0.
  - Reset mid-operation aborts the multiply; the datapath contents are don't-care.
- START conditioning:
  - Three-flop chain s1->s2->s3.
  - start_pulse = s2 & ~s3.
  - A START rise seen at edge k gives start_pulse high during cycle k+1 to k+2. Exactly one pulse per low-to-high transition; a held START does not retrigger.
- States and outputs:
  - IDLE: all outputs inactive. start_pulse -> LOAD.
  - LOAD (exactly 1 cycle): SEL_A=SEL_B=SEL_LOAD, ACC_CLR=1, LD=0, BUSY=1. Clears the iteration counter. Unconditional -> RUN.
  - RUN, EQ=0: LD=1, SEL_A=SEL_SHL, SEL_B=SEL_SHR, BUSY=1. Iteration counter +1.
    - Accumulate and shift happen on the same edge. The datapath adds the current A when B[0]=1, before the shift.
  - RUN, EQ=1: LD=0, SEL_A=SEL_B=SEL_HOLD -> DONE.
  - RUN, counter==ITER_MAX and EQ=0: LD=0, SEL_A=SEL_B=SEL_HOLD, set ERR -> DONE. This is a fault guard; it is unreachable with a correct datapath.
  - DONE: SEL_A=SEL_B=SEL_HOLD, LD=0, DONE=1. start_pulse -> LOAD and clears ERR (ERR stays high through the LOAD cycle and clears on entry to RUN). Otherwise stays in DONE.
- start_pulse in LOAD or RUN is ignored and is not queued.
- The number of LD pulses equals the bit length of B. B=0 gives zero LD pulses and 1 RUN cycle.
- Iteration counter width is clog2(ITER_MAX+1). It saturates and does not wrap.
- Product width: 10 bits. 31x31=961 is the maximum and does not overflow.

Test Plan:
- Multiply 7x5:
  - Stimulus: SW=00111_00101, START pulse.
  - Response: LOAD 1 cycle with ACC_CLR=1; 3 RUN cycles with LD=1; 4th RUN cycle EQ=1 -> DONE; SUM=35; BUSY high for 5 cycles; ERR=0.
- Multiply 31x31:
  - Stimulus: SW=11111_11111.
  - Response: 5 LD pulses, DONE, SUM=961.
- B=0 corner:
  - Stimulus: SW=10110_00000.
  - Response: LOAD, 1 RUN cycle, 0 LD pulses, DONE, SUM=0.
- START handling:
  - Stimulus: START held high 20 cycles.
  - Response: exactly one operation.
  - Stimulus: a second START rise during RUN.
  - Response: ignored.
  - Stimulus: a START rise in DONE.
  - Response: a new LOAD 3 edges later.
- Fault guard:
  - Stimulus: bench holds EQ=0.
  - Response: exactly 5 LD pulses, then DONE=1, ERR=1. The next START clears ERR on RUN entry.
- Async reset:
  - Stimulus: drop CLR_N mid-RUN, between clock edges.
  - Response: LD, BUSY and SEL go inactive immediately; state=IDLE after release; no activity until a new START rise.
